// File: rtl/z80_io_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// z80_bus_pkg
// Shared types and constants for the Z80 I/O bus master slice.
//   bus_state_t   : bus-cycle sequencer states (IDLE, T1, T2, TW, T3, RECOVER)
//   VDP_BASE_PORT : default I/O window base for the V9958 ports $98-$9B
//   port_addr()   : forms A7..A0 from a base and a 2-bit port offset
// ---------------------------------------------------------------------------
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    RECOVER
  } bus_state_t;

  localparam logic [7:0] VDP_BASE_PORT = 8'h98;

  // The base is aligned to four ports, so OR-ing the offset in selects
  // one of the four VDP registers without carry into the upper bits.
  function automatic logic [7:0] port_addr(input logic [7:0] base,
                                           input logic [1:0] port);
    return base | {6'b000000, port};
  endfunction

endpackage

// File: rtl/z80_io_bus_master_if.sv
// ---------------------------------------------------------------------------
// z80_io_bus_master_if
// Bundles the command/response handshake and the Z80 CPU-side pins.
//   command : cmd_valid, cmd_ready, cmd_write, cmd_port[1:0], cmd_data[7:0]
//   response: rsp_valid, rsp_data[7:0], rsp_timeout, busy
//   Z80 bus : bus_addr[7:0], iorq_n, rd_n, wr_n, cd_out[7:0], cd_oe,
//             cd_in[7:0], wait_n, int_n, int_pending
// Modports:
//   master : the bus-cycle generator's view
//   slave  : the command source / bus target view (benches, host logic)
// ---------------------------------------------------------------------------
interface z80_io_bus_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_port;
  logic [7:0] cmd_data;

  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       busy;

  logic [7:0] bus_addr;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] cd_out;
  logic       cd_oe;
  logic [7:0] cd_in;
  logic       wait_n;
  logic       int_n;
  logic       int_pending;

  modport master (
    input  cmd_valid, cmd_write, cmd_port, cmd_data,
    input  cd_in, wait_n, int_n,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
    output bus_addr, iorq_n, rd_n, wr_n, cd_out, cd_oe, int_pending
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_port, cmd_data,
    output cd_in, wait_n, int_n,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy,
    input  bus_addr, iorq_n, rd_n, wr_n, cd_out, cd_oe, int_pending
  );

endinterface

// File: rtl/z80_io_bus_master_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
//   clk_w     in  : destination clock
//   reset_n_w in  : asynchronous active-low reset, both flops load RESET_VAL
//   i_async   in  : asynchronous input level
//   o_sync    out : synchronised level, two clk_w cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_w,
  input  logic reset_n_w,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/z80_io_bus_master.sv
// ---------------------------------------------------------------------------
// z80_io_bus_master
// Turns single-beat commands into Z80-timed IN/OUT cycles on the VDP port
// window and synchronises the VDP interrupt back into the clk_w domain.
//   clk_w     in : master clock
//   reset_n_w in : asynchronous active-low reset (aborts any cycle at once)
//   bus       if : z80_io_bus_master_if.master (command, response, Z80 pins)
// Parameters:
//   TSTATE_CLKS  : clk_w cycles per Z80 T-state (>= 2)
//   BASE_PORT    : I/O base, address = BASE_PORT | cmd_port
//   MAX_WAITS    : extra TW states honoured before forced completion
//   RECOVER_CLKS : idle cycles with all strobes high between bus cycles (>= 1)
// Bus cycle: IDLE -> T1 -> T2 -> TW -> (TW)* -> T3 -> RECOVER -> IDLE.
// ---------------------------------------------------------------------------
module z80_io_bus_master
  import z80_bus_pkg::*;
#(
  parameter int         TSTATE_CLKS  = 8,
  parameter logic [7:0] BASE_PORT    = VDP_BASE_PORT,
  parameter int         MAX_WAITS    = 4,
  parameter int         RECOVER_CLKS = 4
) (
  input logic                 clk_w,
  input logic                 reset_n_w,
  z80_io_bus_master_if.master bus
);

  // One tick counter serves both the T-states and RECOVER, so it is sized
  // for whichever of the two is longer.
  localparam int TICK_MAX = (TSTATE_CLKS > RECOVER_CLKS) ? TSTATE_CLKS : RECOVER_CLKS;
  localparam int TICK_W   = $clog2(TICK_MAX) + 1;
  localparam int WAIT_W   = $clog2(MAX_WAITS + 1) + 1;

  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(TSTATE_CLKS - 1);
  localparam logic [TICK_W-1:0] R_LAST = TICK_W'(RECOVER_CLKS - 1);
  localparam logic [WAIT_W-1:0] W_MAX  = WAIT_W'(MAX_WAITS);

  bus_state_t        r_state;
  logic [TICK_W-1:0] r_tick;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_write;
  logic              r_timeout;

  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp_data;
  logic              r_rsp_timeout;
  logic [7:0]        r_bus_addr;
  logic              r_iorq_n;
  logic              r_rd_n;
  logic              r_wr_n;
  logic [7:0]        r_cd_out;
  logic              r_cd_oe;

  logic              w_wait_sync;
  logic              w_int_sync;
  logic              w_t_last;
  logic              w_r_last;

  sync_2ff #(.RESET_VAL(1'b1)) u_wait_sync (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .i_async   (bus.wait_n),
    .o_sync    (w_wait_sync)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_int_sync (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .i_async   (bus.int_n),
    .o_sync    (w_int_sync)
  );

  assign w_t_last = (r_tick == T_LAST);
  assign w_r_last = (r_tick == R_LAST);

  // Every pin is registered, so each output change appears on the first
  // cycle of the state it belongs to.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_wait_cnt    <= '0;
      r_write       <= 1'b0;
      r_timeout     <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 8'h00;
      r_rsp_timeout <= 1'b0;
      r_bus_addr    <= 8'h00;
      r_iorq_n      <= 1'b1;
      r_rd_n        <= 1'b1;
      r_wr_n        <= 1'b1;
      r_cd_out      <= 8'h00;
      r_cd_oe       <= 1'b0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          // cmd_ready comes up one cycle after reset or RECOVER, which
          // also makes it drop in the same edge that accepts a command.
          if (r_cmd_ready && bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_write     <= bus.cmd_write;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_tick      <= '0;
            r_bus_addr  <= port_addr(BASE_PORT, bus.cmd_port);
            r_cd_out    <= bus.cmd_write ? bus.cmd_data : 8'h00;
            r_cd_oe     <= bus.cmd_write;
            r_state     <= T1;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        T1: begin
          if (w_t_last) begin
            r_tick   <= '0;
            r_iorq_n <= 1'b0;
            r_rd_n   <= r_write;
            r_wr_n   <= ~r_write;
            r_state  <= T2;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        T2: begin
          if (w_t_last) begin
            r_tick  <= '0;
            r_state <= TW;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        TW: begin
          // WAIT_n is judged only at the end of each TW; once the extra
          // waits are used up the cycle completes and is flagged.
          if (w_t_last) begin
            r_tick <= '0;
            if (!w_wait_sync && (r_wait_cnt < W_MAX)) begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
              r_timeout <= ~w_wait_sync;
              r_state   <= T3;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        T3: begin
          if (w_t_last) begin
            r_tick        <= '0;
            r_iorq_n      <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= r_timeout;
            r_rsp_data    <= r_write ? 8'h00 : bus.cd_in;
            r_state       <= RECOVER;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        RECOVER: begin
          // Write data is left on the bus for the first RECOVER cycle as
          // hold time after WR_n rises, then released.
          r_cd_oe <= 1'b0;
          if (w_r_last) begin
            r_tick      <= '0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.busy        = r_busy;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.bus_addr    = r_bus_addr;
  assign bus.iorq_n      = r_iorq_n;
  assign bus.rd_n        = r_rd_n;
  assign bus.wr_n        = r_wr_n;
  assign bus.cd_out      = r_cd_out;
  assign bus.cd_oe       = r_cd_oe;
  assign bus.int_pending = ~w_int_sync;

endmodule

// File: tb/tb_z80_io_bus_master.sv
// ---------------------------------------------------------------------------
// tb_z80_io_bus_master
// Scenario tasks drive z80_io_bus_master through its interface and compare
// what they observe against a cycle-count model of the Z80 I/O cycle.
// Cycle k counts clk_w periods after the accepting edge (k = 1 is the first
// T1 cycle). Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_z80_io_bus_master;
  import z80_bus_pkg::*;

  localparam int TS   = 8;
  localparam int MAXW = 4;
  localparam int REC  = 4;

  logic clk_w     = 1'b0;
  logic reset_n_w = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  always #5 clk_w = ~clk_w;

  z80_io_bus_master_if bus_if ();

  z80_io_bus_master #(
    .TSTATE_CLKS  (TS),
    .BASE_PORT    (8'h98),
    .MAX_WAITS    (MAXW),
    .RECOVER_CLKS (REC)
  ) dut (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .bus       (bus_if)
  );

  typedef struct {
    int         strobeLow;
    int         rspCycle;
    int         oeHigh;
    int         busyHigh;
    int         readyCycle;
    logic       timeout;
    logic [7:0] addr;
    logic [7:0] rspData;
  } txn_exp_t;

  typedef struct {
    int         iorqLow;
    int         rdLow;
    int         wrLow;
    int         oeHigh;
    int         busyHigh;
    int         firstStrobe;
    int         rspCycle;
    int         rspPulses;
    int         readyCycle;
    logic [7:0] addr;
    logic [7:0] rspData;
    logic [7:0] rspDataHeld;
    logic       timeout;
    logic       cdOutOk;
    logic       addrOk;
    logic       overlap;
  } txn_obs_t;

  // Reference: 3 T-states precede the first WAIT decision; each decision
  // sees wait_n as it was two cycles earlier; every honoured wait adds one
  // T-state; response comes one cycle after the last T3 cycle.
  function automatic txn_exp_t model_txn(input logic wr, input logic [1:0] port,
                                         input logic [7:0] rdval, input int ws, input int wl);
    txn_exp_t e;
    int       extra;
    int       dec;
    logic     lowSeen;
    extra     = 0;
    dec       = 3 * TS;
    e.timeout = 1'b0;
    for (int i = 0; i <= MAXW; i++) begin
      lowSeen = ((dec - 2) >= ws) && ((dec - 2) < (ws + wl));
      if (lowSeen && extra < MAXW) begin
        extra = extra + 1;
        dec   = dec + TS;
      end else begin
        e.timeout = lowSeen;
        break;
      end
    end
    e.strobeLow  = 3 * TS + TS * extra;
    e.rspCycle   = 4 * TS + 1 + TS * extra;
    e.oeHigh     = wr ? e.rspCycle : 0;
    e.busyHigh   = e.rspCycle + REC - 1;
    e.readyCycle = e.rspCycle + REC;
    e.addr       = 8'h98 | {6'b000000, port};
    e.rspData    = wr ? 8'h00 : rdval;
    return e;
  endfunction

  // Issues one command and records what the bus did until cmd_ready returns.
  // cd_in carries rdval only during T3 and its complement otherwise.
  task automatic drive_txn(input logic wr, input logic [1:0] port, input logic [7:0] data,
                           input logic [7:0] rdval, input int ws, input int wl,
                           input int t3End, output txn_obs_t o);
    int n;
    o = '{iorqLow: 0, rdLow: 0, wrLow: 0, oeHigh: 0, busyHigh: 0, firstStrobe: -1,
          rspCycle: -1, rspPulses: 0, readyCycle: -1, addr: 8'h00, rspData: 8'h00,
          rspDataHeld: 8'h00, timeout: 1'b0, cdOutOk: 1'b1, addrOk: 1'b1, overlap: 1'b0};
    n = 0;
    while (!bus_if.cmd_ready && n < 60) begin
      @(negedge clk_w);
      n++;
    end
    if (!bus_if.cmd_ready) return;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_port  = port;
    bus_if.cmd_data  = data;
    bus_if.wait_n    = 1'b1;
    bus_if.cd_in     = ~rdval;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk_w);
      if (k == 1) begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'($urandom);
        bus_if.cmd_port  = 2'($urandom);
        bus_if.cmd_data  = 8'($urandom);
      end
      if (!bus_if.iorq_n) begin
        o.iorqLow++;
        if (o.firstStrobe < 0) o.firstStrobe = k;
      end
      if (!bus_if.rd_n) o.rdLow++;
      if (!bus_if.wr_n) o.wrLow++;
      if (!bus_if.rd_n && !bus_if.wr_n) o.overlap = 1'b1;
      if (bus_if.cd_oe) begin
        o.oeHigh++;
        if (bus_if.cd_out !== data) o.cdOutOk = 1'b0;
      end
      if (bus_if.busy) o.busyHigh++;
      if (k == 1) o.addr = bus_if.bus_addr;
      else if (bus_if.bus_addr !== o.addr) o.addrOk = 1'b0;
      if (bus_if.rsp_valid) begin
        o.rspPulses++;
        o.rspCycle = k;
        o.rspData  = bus_if.rsp_data;
        o.timeout  = bus_if.rsp_timeout;
      end
      if (bus_if.cmd_ready) begin
        o.readyCycle  = k;
        o.rspDataHeld = bus_if.rsp_data;
        break;
      end
      bus_if.wait_n = !(k >= ws && k < ws + wl);
      bus_if.cd_in  = (k > t3End - TS && k <= t3End) ? rdval : ~rdval;
    end
    bus_if.wait_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_w);
    checks++; if ({bus_if.iorq_n, bus_if.rd_n, bus_if.wr_n} !== 3'b111) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 111", {bus_if.iorq_n, bus_if.rd_n, bus_if.wr_n}); end
    checks++; if (bus_if.cd_oe !== 1'b0 || bus_if.cd_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_cd: got oe=%b out=%h want 0/00", bus_if.cd_oe, bus_if.cd_out); end
    checks++; if (bus_if.bus_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h want 00", bus_if.bus_addr); end
    checks++; if ({bus_if.cmd_ready, bus_if.busy, bus_if.rsp_valid, bus_if.rsp_timeout} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctrl: got %b want 0000", {bus_if.cmd_ready, bus_if.busy, bus_if.rsp_valid, bus_if.rsp_timeout}); end
    checks++; if (bus_if.rsp_data !== 8'h00 || bus_if.int_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_int: got data=%h int=%b want 00/0", bus_if.rsp_data, bus_if.int_pending); end
    reset_n_w = 1'b1;
    @(negedge clk_w);
    checks++; if (bus_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_rise: got %b want 1", bus_if.cmd_ready); end
  endtask

  // OUT to port 1 with 0x8F.
  task automatic test_write();
    txn_exp_t e;
    txn_obs_t o;
    e = model_txn(1'b1, 2'd1, 8'h00, 0, 0);
    drive_txn(1'b1, 2'd1, 8'h8F, 8'h00, 0, 0, e.rspCycle - 1, o);
    checks++; if (o.addr !== 8'h99) begin errors++; $display("[TB] FAIL write_addr: got %h want 99", o.addr); end
    checks++; if (o.wrLow !== e.strobeLow) begin errors++; $display("[TB] FAIL write_wr_low: got %0d want %0d", o.wrLow, e.strobeLow); end
    checks++; if (o.rdLow !== 0) begin errors++; $display("[TB] FAIL write_rd_low: got %0d want 0", o.rdLow); end
    checks++; if (o.firstStrobe !== 2 * TS + 1 - TS) begin errors++; $display("[TB] FAIL write_first_strobe: got %0d want %0d", o.firstStrobe, TS + 1); end
    checks++; if (o.oeHigh !== e.oeHigh) begin errors++; $display("[TB] FAIL write_oe_len: got %0d want %0d", o.oeHigh, e.oeHigh); end
    checks++; if (o.cdOutOk !== 1'b1) begin errors++; $display("[TB] FAIL write_cd_out: got bad=%b want 8f throughout", ~o.cdOutOk); end
    checks++; if (o.rspCycle !== e.rspCycle) begin errors++; $display("[TB] FAIL write_rsp_latency: got %0d want %0d", o.rspCycle, e.rspCycle); end
    checks++; if (o.timeout !== 1'b0 || o.rspData !== 8'h00) begin errors++; $display("[TB] FAIL write_rsp_fields: got to=%b data=%h want 0/00", o.timeout, o.rspData); end
  endtask

  // IN from port 0 with the target returning 0x5A.
  task automatic test_read();
    txn_exp_t e;
    txn_obs_t o;
    e = model_txn(1'b0, 2'd0, 8'h5A, 0, 0);
    drive_txn(1'b0, 2'd0, 8'h00, 8'h5A, 0, 0, e.rspCycle - 1, o);
    checks++; if (o.addr !== 8'h98) begin errors++; $display("[TB] FAIL read_addr: got %h want 98", o.addr); end
    checks++; if (o.rdLow !== e.strobeLow || o.wrLow !== 0) begin errors++; $display("[TB] FAIL read_strobes: got rd=%0d wr=%0d want %0d/0", o.rdLow, o.wrLow, e.strobeLow); end
    checks++; if (o.rspData !== 8'h5A) begin errors++; $display("[TB] FAIL read_data: got %h want 5a", o.rspData); end
    checks++; if (o.rspPulses !== 1) begin errors++; $display("[TB] FAIL read_rsp_pulses: got %0d want 1", o.rspPulses); end
    checks++; if (o.oeHigh !== 0) begin errors++; $display("[TB] FAIL read_oe: got %0d want 0", o.oeHigh); end
    checks++; if (o.rspDataHeld !== 8'h5A) begin errors++; $display("[TB] FAIL read_data_held: got %h want 5a", o.rspDataHeld); end
  endtask

  // wait_n low for the first 12 cycles of TW: one extra TW is inserted.
  task automatic test_one_wait();
    txn_exp_t e;
    txn_obs_t o;
    e = model_txn(1'b1, 2'd2, 8'h00, 2 * TS + 1, 12);
    drive_txn(1'b1, 2'd2, 8'h3C, 8'h00, 2 * TS + 1, 12, e.rspCycle - 1, o);
    checks++; if (o.iorqLow !== e.strobeLow || o.wrLow !== e.strobeLow) begin errors++; $display("[TB] FAIL wait1_strobe_len: got iorq=%0d wr=%0d want %0d", o.iorqLow, o.wrLow, e.strobeLow); end
    checks++; if (o.rspCycle !== e.rspCycle) begin errors++; $display("[TB] FAIL wait1_rsp_latency: got %0d want %0d", o.rspCycle, e.rspCycle); end
    checks++; if (o.timeout !== 1'b0) begin errors++; $display("[TB] FAIL wait1_timeout: got %b want 0", o.timeout); end
  endtask

  // wait_n stuck low: all extra waits used, then forced completion.
  task automatic test_wait_timeout();
    txn_exp_t e;
    txn_obs_t o;
    e = model_txn(1'b0, 2'd3, 8'hC3, TS + 1, 200);
    drive_txn(1'b0, 2'd3, 8'h00, 8'hC3, TS + 1, 200, e.rspCycle - 1, o);
    checks++; if (o.iorqLow !== e.strobeLow) begin errors++; $display("[TB] FAIL waitmax_strobe_len: got %0d want %0d", o.iorqLow, e.strobeLow); end
    checks++; if (o.timeout !== 1'b1 || o.rspPulses !== 1) begin errors++; $display("[TB] FAIL waitmax_timeout: got to=%b pulses=%0d want 1/1", o.timeout, o.rspPulses); end
    checks++; if (o.readyCycle !== e.readyCycle) begin errors++; $display("[TB] FAIL waitmax_idle_return: got %0d want %0d", o.readyCycle, e.readyCycle); end
    checks++; if (o.rspData !== 8'hC3) begin errors++; $display("[TB] FAIL waitmax_data: got %h want c3", o.rspData); end
  endtask

  task automatic test_random();
    txn_exp_t   e;
    txn_obs_t   o;
    logic       wr;
    logic [1:0] port;
    logic [7:0] data;
    logic [7:0] rdval;
    int         ws;
    int         wl;
    for (int i = 0; i < 8; i++) begin
      wr    = 1'($urandom_range(0, 1));
      port  = 2'($urandom_range(0, 3));
      data  = 8'($urandom_range(0, 255));
      rdval = 8'($urandom_range(0, 255));
      ws    = $urandom_range(TS + 1, 60);
      wl    = $urandom_range(0, 45);
      e     = model_txn(wr, port, rdval, ws, wl);
      drive_txn(wr, port, data, rdval, ws, wl, e.rspCycle - 1, o);
      checks++; if (o.iorqLow !== e.strobeLow) begin errors++; $display("[TB] FAIL rand%0d_iorq_len: got %0d want %0d", i, o.iorqLow, e.strobeLow); end
      checks++; if (o.rdLow !== (wr ? 0 : e.strobeLow) || o.wrLow !== (wr ? e.strobeLow : 0)) begin errors++; $display("[TB] FAIL rand%0d_rw_len: got rd=%0d wr=%0d write=%b", i, o.rdLow, o.wrLow, wr); end
      checks++; if (o.rspCycle !== e.rspCycle || o.rspPulses !== 1) begin errors++; $display("[TB] FAIL rand%0d_rsp: got cyc=%0d pulses=%0d want %0d/1", i, o.rspCycle, o.rspPulses, e.rspCycle); end
      checks++; if (o.rspData !== e.rspData || o.timeout !== e.timeout) begin errors++; $display("[TB] FAIL rand%0d_rsp_fields: got %h/%b want %h/%b", i, o.rspData, o.timeout, e.rspData, e.timeout); end
      checks++; if (o.oeHigh !== e.oeHigh || o.cdOutOk !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_cd: got oe=%0d ok=%b want %0d/1", i, o.oeHigh, o.cdOutOk, e.oeHigh); end
      checks++; if (o.busyHigh !== e.busyHigh || o.readyCycle !== e.readyCycle) begin errors++; $display("[TB] FAIL rand%0d_busy: got %0d/%0d want %0d/%0d", i, o.busyHigh, o.readyCycle, e.busyHigh, e.readyCycle); end
      checks++; if (o.addr !== e.addr || o.addrOk !== 1'b1 || o.overlap !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_addr: got %h stable=%b ovl=%b want %h", i, o.addr, o.addrOk, o.overlap, e.addr); end
    end
  endtask

  // cmd_valid held across three commands, fields changed after each accept.
  task automatic test_back_to_back();
    int   n = 0;
    int   accepts = 0;
    int   rsps = 0;
    int   gap = 0;
    int   gapMin = 1000;
    int   rspLast = -1;
    logic seenLow = 1'b0;
    logic overlap = 1'b0;
    logic periodBad = 1'b0;
    logic dropNext = 1'b0;
    logic changeNext = 1'b0;
    while (!bus_if.cmd_ready && n < 60) begin
      @(negedge clk_w);
      n++;
    end
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'($urandom);
    bus_if.cmd_port  = 2'($urandom);
    bus_if.cmd_data  = 8'($urandom);
    bus_if.wait_n    = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        accepts++;
        if (accepts == 3) dropNext = 1'b1;
        else changeNext = 1'b1;
      end
      @(negedge clk_w);
      if (dropNext) begin
        bus_if.cmd_valid = 1'b0;
        dropNext = 1'b0;
      end
      if (changeNext) begin
        bus_if.cmd_write = 1'($urandom);
        bus_if.cmd_port  = 2'($urandom);
        bus_if.cmd_data  = 8'($urandom);
        changeNext = 1'b0;
      end
      if (!bus_if.iorq_n || !bus_if.rd_n || !bus_if.wr_n) begin
        if (seenLow && gap > 0 && gap < gapMin) gapMin = gap;
        seenLow = 1'b1;
        gap = 0;
      end else if (seenLow) begin
        gap++;
      end
      if (!bus_if.rd_n && !bus_if.wr_n) overlap = 1'b1;
      if (bus_if.rsp_valid) begin
        if (rspLast >= 0 && (k - rspLast) != 4 * TS + REC + 1) periodBad = 1'b1;
        rspLast = k;
        rsps++;
      end
      if (rsps == 3 && bus_if.cmd_ready) break;
    end
    bus_if.cmd_valid = 1'b0;
    checks++; if (accepts !== 3 || rsps !== 3) begin errors++; $display("[TB] FAIL b2b_counts: got acc=%0d rsp=%0d want 3/3", accepts, rsps); end
    checks++; if (gapMin < REC || gapMin == 1000) begin errors++; $display("[TB] FAIL b2b_gap: got %0d want >= %0d", gapMin, REC); end
    checks++; if (periodBad !== 1'b0 || overlap !== 1'b0) begin errors++; $display("[TB] FAIL b2b_timing: got period_bad=%b overlap=%b want 0/0", periodBad, overlap); end
  endtask

  // Reset asserted in T2 of a write aborts the cycle with no response.
  task automatic test_reset_abort();
    int n = 0;
    int rspSeen = 0;
    int lowSeen = 0;
    while (!bus_if.cmd_ready && n < 60) begin
      @(negedge clk_w);
      n++;
    end
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_port  = 2'd0;
    bus_if.cmd_data  = 8'hA5;
    for (int k = 1; k <= TS + 4; k++) begin
      @(negedge clk_w);
      if (k == 1) bus_if.cmd_valid = 1'b0;
    end
    checks++; if (bus_if.wr_n !== 1'b0 || bus_if.cd_oe !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_t2: got wr_n=%b oe=%b want 0/1", bus_if.wr_n, bus_if.cd_oe); end
    reset_n_w = 1'b0;
    #1;
    checks++; if ({bus_if.iorq_n, bus_if.rd_n, bus_if.wr_n} !== 3'b111 || bus_if.cd_oe !== 1'b0) begin errors++; $display("[TB] FAIL abort_pins: got %b oe=%b want 111/0", {bus_if.iorq_n, bus_if.rd_n, bus_if.wr_n}, bus_if.cd_oe); end
    checks++; if (bus_if.busy !== 1'b0 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_ctrl: got busy=%b rsp=%b want 0/0", bus_if.busy, bus_if.rsp_valid); end
    @(negedge clk_w);
    reset_n_w = 1'b1;
    repeat (60) begin
      @(negedge clk_w);
      if (bus_if.rsp_valid) rspSeen++;
      if (!bus_if.iorq_n || !bus_if.wr_n) lowSeen++;
    end
    checks++; if (rspSeen !== 0 || lowSeen !== 0) begin errors++; $display("[TB] FAIL abort_after: got rsp=%0d low=%0d want 0/0", rspSeen, lowSeen); end
    checks++; if (bus_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b want 1", bus_if.cmd_ready); end
  endtask

  task automatic test_int_sync();
    @(negedge clk_w);
    bus_if.int_n = 1'b0;
    @(posedge clk_w); #1;
    checks++; if (bus_if.int_pending !== 1'b0) begin errors++; $display("[TB] FAIL int_one_clk: got %b want 0", bus_if.int_pending); end
    @(posedge clk_w); #1;
    checks++; if (bus_if.int_pending !== 1'b1) begin errors++; $display("[TB] FAIL int_two_clk: got %b want 1", bus_if.int_pending); end
    @(negedge clk_w);
    bus_if.int_n = 1'b1;
    repeat (2) @(posedge clk_w);
    #1;
    checks++; if (bus_if.int_pending !== 1'b0) begin errors++; $display("[TB] FAIL int_release: got %b want 0", bus_if.int_pending); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_port  = 2'd0;
    bus_if.cmd_data  = 8'h00;
    bus_if.cd_in     = 8'h00;
    bus_if.wait_n    = 1'b1;
    bus_if.int_n     = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_one_wait();
    test_wait_timeout();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_int_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
